// File: rtl/i2s_loop_fifo.sv
// i2s_loop_fifo: stereo sample FIFO that sits between the I2S receiver and
// the I2S transmitter, so that ADC audio can loop back to the DAC.
//
// Each frame holds a left and a right sample. Every read request is answered
// on the next cycle, even when the FIFO is empty: an empty FIFO returns 0/0
// and the miss is counted. The fill level is reported directly. Dropped
// writes (overflow) and empty reads (underflow) are counted with saturating
// counters for debug.
//
// Optional build macro: I2S_LOOP_FIFO_PREFILL_EN
//   When defined, a FILL/RUN state machine holds off popping until the FIFO
//   is half full. It drops back to FILL on any underflow. While in FILL,
//   reads return 0/0 without popping and without counting an underflow.
//   When undefined, the FIFO is permanently in RUN.

module i2s_loop_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            wr_ldata,
  input  logic [DW-1:0]            wr_rdata,
  input  logic                     wr_valid,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [DW-1:0]            rd_ldata,
  output logic [DW-1:0]            rd_rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [CW-1:0]            overflow_count,
  output logic [CW-1:0]            underflow_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = 2 * DW;

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_HALF = LW'(DEPTH / 2);

  // Saturating event-counter increment: holds at all-ones rather than wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value);
    logic [CW-1:0] result;
    if (value == {CW{1'b1}}) begin
      result = value;
    end else begin
      result = value + 1'b1;
    end
    return result;
  endfunction

  // Frame storage; the left sample sits in the upper half of each word.
  logic [FW-1:0]   mem [DEPTH];

  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [LW-1:0]   level_q;
  logic [LW-1:0]   level_next;
  logic [CW-1:0]   ovf_cnt;
  logic [CW-1:0]   unf_cnt;

  logic            is_full;
  logic            is_empty;
  logic            run;
  logic            pop;
  logic            push;
  logic            unf_evt;
  logic            ovf_evt;

  logic [FW-1:0]   rd_frame;

  logic                 vld_p1;
  logic signed [DW-1:0] ldata_p1;
  logic signed [DW-1:0] rdata_p1;

  assign is_full  = (level_q == LEVEL_FULL);
  assign is_empty = (level_q == '0);
  assign rd_frame = mem[rptr];

`ifdef I2S_LOOP_FIFO_PREFILL_EN
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  assign run = (state == RUN);

  // Prefill state register; reset always restarts the fill phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Leave FILL once the level reaches half depth; fall back on any underflow.
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (level_next >= LEVEL_HALF) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (unf_evt) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end
`else
  assign run = 1'b1;
`endif

  // Decide this cycle's pop/push and the resulting level.
  // The pop is decided first. A write into a full FIFO that pops in the same
  // cycle is accepted, because the pop frees a slot. There is no write-to-read
  // bypass, so a read of an empty FIFO underflows even when a write arrives in
  // the same cycle.
  always_comb begin
    pop        = rd_en & run & ~is_empty;
    unf_evt    = rd_en & run & is_empty;
    push       = wr_valid & (~is_full | pop);
    ovf_evt    = wr_valid & is_full & ~pop;
    level_next = level_q;
    case ({push, pop})
      2'b10:   level_next = level_q + 1'b1;
      2'b01:   level_next = level_q - 1'b1;
      default: level_next = level_q;
    endcase
  end

  // Frame storage write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {wr_ldata, wr_rdata};
    end
  end

  // Pointers, level and saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      level_q <= level_next;
      if (ovf_evt) begin
        ovf_cnt <= sat_inc(ovf_cnt);
      end
      if (unf_evt) begin
        unf_cnt <= sat_inc(unf_cnt);
      end
    end
  end

  // ---- stage p1: read response, one cycle after rd_en ----
  // Every request gets a strobe. The data is the popped frame or 0/0, and it
  // is held between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      ldata_p1 <= '0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) begin
        if (pop) begin
          ldata_p1 <= rd_frame[FW-1:DW];
          rdata_p1 <= rd_frame[DW-1:0];
        end else begin
          ldata_p1 <= '0;
          rdata_p1 <= '0;
        end
      end
    end
  end

  assign rd_valid        = vld_p1;
  assign rd_ldata        = ldata_p1;
  assign rd_rdata        = rdata_p1;
  assign level           = level_q;
  assign full            = is_full;
  assign empty           = is_empty;
  assign overflow_count  = ovf_cnt;
  assign underflow_count = unf_cnt;

endmodule
